// File: rtl/cmd_decoder_pkg.sv
// Shared definitions for the command-frame decoder: command codes,
// FSM state encoding and ALU function codes.
package cmd_decoder_pkg;

   // Command bytes, zero-extended to the data width at the point of use
   localparam logic [7:0] CMD_WRITE    = 8'hAA;
   localparam logic [7:0] CMD_READ     = 8'hBB;
   localparam logic [7:0] CMD_ALU_OPS  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOOP = 8'hDD;
   localparam logic [7:0] CMD_BURST    = 8'hEE;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_OPA,
      ST_OPB,
      ST_FUN,
      ST_BW_ADDR,
      ST_BW_LEN,
      ST_BW_DATA
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD     = 4'd0,
      ALU_SUB     = 4'd1,
      ALU_MUL     = 4'd2,
      ALU_DIV     = 4'd3,
      ALU_AND     = 4'd4,
      ALU_OR      = 4'd5,
      ALU_NAND    = 4'd6,
      ALU_NOR     = 4'd7,
      ALU_XOR     = 4'd8,
      ALU_XNOR    = 4'd9,
      ALU_CMP_EQ  = 4'd10,
      ALU_CMP_GT  = 4'd11,
      ALU_CMP_LT  = 4'd12,
      ALU_SHR     = 4'd13,
      ALU_SHL     = 4'd14,
      ALU_INVALID = 4'd15
   } alu_fun_t;

endpackage

// File: rtl/frame_timeout_counter.sv
// Mid-frame idle watchdog. Counts cycles with run high; clear restarts it.
// expire is combinational and marks the TIMEOUT_CYCLES-th consecutive run
// cycle so the owner can abort on that same clock edge.
module frame_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk, reset, clear, run};
         assign expire        = 1'b0;
      end else begin : g_on
         localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Next count: restart on clear, wrap to zero on expiry
         always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
               cnt_d = '0;
            end else if (run) begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
         end

         // Count register
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expire = run && !clear && (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/cmd_frame_decoder.sv
// Command-frame decoder: turns received UART bytes into single-cycle
// register-file write/read and ALU strobes, with burst writes, malformed
// frame reporting and a mid-frame idle watchdog. All outputs registered.
module cmd_frame_decoder
   import cmd_decoder_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int OPA_ADDR       = 0,
   parameter int OPB_ADDR       = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   output logic                  rf_wr_en,
   output logic [DATA_WIDTH-1:0] rf_wr_data,
   output logic                  rf_rd_en,
   output logic                  alu_en,
   output logic [3:0]            alu_fun,
   output logic                  alu_clk_en,
   output logic                  clk_div_en,
   output logic                  cmd_err,
   output logic                  busy
);

   localparam logic [DATA_WIDTH-1:0] FUN_MAX = DATA_WIDTH'(ALU_SHL);
   localparam logic [DATA_WIDTH-1:0] LEN_ONE = DATA_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] len_q, len_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic                  rf_wr_en_q, rf_wr_en_d;
   logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
   logic                  rf_rd_en_q, rf_rd_en_d;
   logic                  alu_en_q, alu_en_d;
   logic [3:0]            alu_fun_q, alu_fun_d;
   logic                  alu_clk_en_q, alu_clk_en_d;
   logic                  clk_div_en_q, clk_div_en_d;
   logic                  cmd_err_q, cmd_err_d;
   logic                  busy_q, busy_d;

   logic                  wd_clear;
   logic                  wd_run;
   logic                  wd_expire;
   logic                  addr_ok;
   logic [ADDR_WIDTH-1:0] rx_addr;

   // Compare a received byte against an 8-bit command code, both zero-extended
   // so narrow data widths never alias onto a truncated code.
   function automatic logic is_cmd(input logic [DATA_WIDTH-1:0] b,
                                   input logic [7:0]            code);
      return {8'h00, b} == {{DATA_WIDTH{1'b0}}, code};
   endfunction

   assign rx_addr = rx_data[ADDR_WIDTH-1:0];
   assign addr_ok = (rx_data >> ADDR_WIDTH) == '0;

   // Watchdog runs only mid-frame on cycles without a byte
   assign wd_clear = rx_valid || (state_q == ST_IDLE);
   assign wd_run   = (state_q != ST_IDLE) && !rx_valid;

   frame_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .run    (wd_run),
      .expire (wd_expire)
   );

   // Frame FSM next state and registered-output next values
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      rf_addr_d    = rf_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      alu_fun_d    = alu_fun_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      alu_en_d     = 1'b0;
      cmd_err_d    = 1'b0;
      clk_div_en_d = 1'b1;

      if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (is_cmd(rx_data, CMD_WRITE)) begin
                  state_d = ST_WR_ADDR;
               end else if (is_cmd(rx_data, CMD_READ)) begin
                  state_d = ST_RD_ADDR;
               end else if (is_cmd(rx_data, CMD_ALU_OPS)) begin
                  state_d = ST_OPA;
               end else if (is_cmd(rx_data, CMD_ALU_NOOP)) begin
                  state_d = ST_FUN;
               end else if (is_cmd(rx_data, CMD_BURST)) begin
                  state_d = ST_BW_ADDR;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            ST_WR_ADDR, ST_BW_ADDR: begin
               if (addr_ok) begin
                  addr_d  = rx_addr;
                  state_d = (state_q == ST_WR_ADDR) ? ST_WR_DATA : ST_BW_LEN;
               end else begin
                  cmd_err_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_WR_DATA: begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = addr_q;
               rf_wr_data_d = rx_data;
               state_d      = ST_IDLE;
            end
            ST_RD_ADDR: begin
               if (addr_ok) begin
                  rf_rd_en_d = 1'b1;
                  rf_addr_d  = rx_addr;
               end else begin
                  cmd_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            ST_OPA: begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
               rf_wr_data_d = rx_data;
               state_d      = ST_OPB;
            end
            ST_OPB: begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
               rf_wr_data_d = rx_data;
               state_d      = ST_FUN;
            end
            ST_FUN: begin
               if (rx_data > FUN_MAX) begin
                  cmd_err_d = 1'b1;
               end else begin
                  alu_en_d  = 1'b1;
                  alu_fun_d = rx_data[3:0];
               end
               state_d = ST_IDLE;
            end
            ST_BW_LEN: begin
               if (rx_data == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  len_d   = rx_data;
                  state_d = ST_BW_DATA;
               end
            end
            ST_BW_DATA: begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = addr_q;
               rf_wr_data_d = rx_data;
               addr_d       = addr_q + 1'b1;
               len_d        = len_q - 1'b1;
               if (len_q == LEN_ONE) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (wd_expire) begin
         cmd_err_d = 1'b1;
         state_d   = ST_IDLE;
      end

      alu_clk_en_d = (state_d == ST_FUN) || alu_en_d;
      busy_d       = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         rf_addr_q    <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_wr_data_q <= '0;
         rf_rd_en_q   <= 1'b0;
         alu_en_q     <= 1'b0;
         alu_fun_q    <= ALU_INVALID;
         alu_clk_en_q <= 1'b0;
         clk_div_en_q <= 1'b0;
         cmd_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         rf_addr_q    <= rf_addr_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_wr_data_q <= rf_wr_data_d;
         rf_rd_en_q   <= rf_rd_en_d;
         alu_en_q     <= alu_en_d;
         alu_fun_q    <= alu_fun_d;
         alu_clk_en_q <= alu_clk_en_d;
         clk_div_en_q <= clk_div_en_d;
         cmd_err_q    <= cmd_err_d;
         busy_q       <= busy_d;
      end
   end

   assign rf_addr    = rf_addr_q;
   assign rf_wr_en   = rf_wr_en_q;
   assign rf_wr_data = rf_wr_data_q;
   assign rf_rd_en   = rf_rd_en_q;
   assign alu_en     = alu_en_q;
   assign alu_fun    = alu_fun_q;
   assign alu_clk_en = alu_clk_en_q;
   assign clk_div_en = clk_div_en_q;
   assign cmd_err    = cmd_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Scoreboard bench for cmd_frame_decoder: each scenario pushes the strobes it
// expects (kind, address, data, function, cycle) and compares them with the
// strobes captured from the DUT.
module tb_cmd_frame_decoder;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;

   localparam logic [2:0] K_WR  = 3'd1;
   localparam logic [2:0] K_RD  = 3'd2;
   localparam logic [2:0] K_ALU = 3'd3;
   localparam logic [2:0] K_ERR = 3'd4;

   typedef struct packed {
      logic [2:0]  kind;
      logic [3:0]  addr;
      logic [7:0]  data;
      logic [3:0]  fun;
      logic [15:0] cyc;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic [AW-1:0] rf_addr;
   logic          rf_wr_en;
   logic [DW-1:0] rf_wr_data;
   logic          rf_rd_en;
   logic          alu_en;
   logic [3:0]    alu_fun;
   logic          alu_clk_en;
   logic          clk_div_en;
   logic          cmd_err;
   logic          busy;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;

   cmd_frame_decoder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .OPA_ADDR(0), .OPB_ADDR(1)
   ) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
      .rf_rd_en(rf_rd_en), .alu_en(alu_en), .alu_fun(alu_fun),
      .alu_clk_en(alu_clk_en), .clk_div_en(clk_div_en), .cmd_err(cmd_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every strobe with the cycle it appeared in
   always @(negedge clk) begin
      if (!reset) begin
         if (rf_wr_en) obs_q.push_back('{K_WR, rf_addr, rf_wr_data, 4'h0, 16'(cyc)});
         if (rf_rd_en) obs_q.push_back('{K_RD, rf_addr, 8'h00, 4'h0, 16'(cyc)});
         if (alu_en)   obs_q.push_back('{K_ALU, 4'h0, 8'h00, alu_fun, 16'(cyc)});
         if (cmd_err)  obs_q.push_back('{K_ERR, 4'h0, 8'h00, 4'h0, 16'(cyc)});
      end
   end

   function automatic void expect_ev(input logic [2:0] k, input logic [3:0] a,
                                     input logic [7:0] d, input logic [3:0] f, input int c);
      exp_q.push_back('{k, a, d, f, 16'(c)});
   endfunction

   // Drive one byte for exactly one cycle; 'at' is the cycle it is presented in
   task automatic send_byte(input logic [7:0] b, output int at);
      at       = cyc;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rf_addr !== 4'h0)    begin n_bad++; $display("FAIL reset_rf_addr: got %h want 0", rf_addr); end
      n_cmp++; if (rf_wr_en !== 1'b0)   begin n_bad++; $display("FAIL reset_rf_wr_en: got %b want 0", rf_wr_en); end
      n_cmp++; if (rf_wr_data !== 8'h0) begin n_bad++; $display("FAIL reset_rf_wr_data: got %h want 0", rf_wr_data); end
      n_cmp++; if (rf_rd_en !== 1'b0)   begin n_bad++; $display("FAIL reset_rf_rd_en: got %b want 0", rf_rd_en); end
      n_cmp++; if (alu_en !== 1'b0)     begin n_bad++; $display("FAIL reset_alu_en: got %b want 0", alu_en); end
      n_cmp++; if (alu_fun !== 4'hF)    begin n_bad++; $display("FAIL reset_alu_fun: got %h want f", alu_fun); end
      n_cmp++; if (alu_clk_en !== 1'b0) begin n_bad++; $display("FAIL reset_alu_clk_en: got %b want 0", alu_clk_en); end
      n_cmp++; if (clk_div_en !== 1'b0) begin n_bad++; $display("FAIL reset_clk_div_en: got %b want 0", clk_div_en); end
      n_cmp++; if (cmd_err !== 1'b0)    begin n_bad++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (clk_div_en !== 1'b1) begin n_bad++; $display("FAIL release_clk_div_en: got %b want 1", clk_div_en); end
      idle(2);
   endtask

   task automatic test_write;
      int t0, t1, t2;
      ev_t e, o;
      send_byte(8'hAA, t0);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy_rise: got %b want 1", busy); end
      send_byte(8'h05, t1);
      send_byte(8'h3C, t2);
      expect_ev(K_WR, 4'h5, 8'h3C, 4'h0, t2 + 1);
      idle(4);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_fall: got %b want 0", busy); end
      n_cmp++; if (rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
         n_bad++; $display("FAIL write_hold: got addr=%h data=%h want addr=5 data=3c", rf_addr, rf_wr_data);
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL write_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL write_event: got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_alu_back_to_back;
      int t0, t1, t2, t3, t4, t5;
      ev_t e, o;
      send_byte(8'hCC, t0);
      send_byte(8'h07, t1);
      send_byte(8'h09, t2);
      n_cmp++; if (alu_clk_en !== 1'b1) begin n_bad++; $display("FAIL alu_clk_en_fun: got %b want 1", alu_clk_en); end
      send_byte(8'h02, t3);
      n_cmp++; if (alu_clk_en !== 1'b1) begin n_bad++; $display("FAIL alu_clk_en_strobe: got %b want 1", alu_clk_en); end
      send_byte(8'hBB, t4);
      n_cmp++; if (alu_clk_en !== 1'b0) begin n_bad++; $display("FAIL alu_clk_en_after: got %b want 0", alu_clk_en); end
      send_byte(8'h01, t5);
      expect_ev(K_WR, 4'h0, 8'h07, 4'h0, t1 + 1);
      expect_ev(K_WR, 4'h1, 8'h09, 4'h0, t2 + 1);
      expect_ev(K_ALU, 4'h0, 8'h00, 4'h2, t3 + 1);
      expect_ev(K_RD, 4'h1, 8'h00, 4'h0, t5 + 1);
      idle(4);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL alu_b2b_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL alu_b2b_event: got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_burst;
      int t;
      logic [7:0] frame [0:5];
      ev_t e, o;
      frame = '{8'hEE, 8'h0E, 8'h03, 8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 6; i++) begin
         send_byte(frame[i], t);
         if (i >= 3) expect_ev(K_WR, 4'(14 + i - 3), frame[i], 4'h0, t + 1);
      end
      send_byte(8'hEE, t);
      send_byte(8'h04, t);
      send_byte(8'h00, t);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_len0_busy: got %b want 0", busy); end
      idle(4);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL burst_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL burst_event: got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_errors;
      int t;
      ev_t e, o;
      send_byte(8'h5A, t); expect_ev(K_ERR, 4'h0, 8'h00, 4'h0, t + 1);
      send_byte(8'hAA, t);
      send_byte(8'h1F, t); expect_ev(K_ERR, 4'h0, 8'h00, 4'h0, t + 1);
      send_byte(8'hBB, t);
      send_byte(8'h10, t); expect_ev(K_ERR, 4'h0, 8'h00, 4'h0, t + 1);
      send_byte(8'hDD, t);
      send_byte(8'h0E, t); expect_ev(K_ALU, 4'h0, 8'h00, 4'hE, t + 1);
      send_byte(8'hDD, t);
      send_byte(8'h0F, t); expect_ev(K_ERR, 4'h0, 8'h00, 4'h0, t + 1);
      idle(4);
      n_cmp++; if (alu_fun !== 4'hE) begin n_bad++; $display("FAIL err_alu_fun_hold: got %h want e", alu_fun); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_busy: got %b want 0", busy); end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL err_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL err_event: got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_timeout;
      int t;
      ev_t e, o;
      // Silence after the command: abort after TO idle cycles
      send_byte(8'hAA, t);
      expect_ev(K_ERR, 4'h0, 8'h00, 4'h0, t + 1 + TO);
      idle(TO + 4);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
      // Byte arriving on the expiry cycle is accepted instead
      send_byte(8'hAA, t);
      idle(TO - 1);
      send_byte(8'h05, t);
      send_byte(8'h3C, t);
      expect_ev(K_WR, 4'h5, 8'h3C, 4'h0, t + 1);
      idle(4);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL timeout_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL timeout_event: got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_frame;
      int t;
      ev_t e, o;
      send_byte(8'hEE, t);
      send_byte(8'h02, t);
      send_byte(8'h05, t);
      send_byte(8'h11, t);
      expect_ev(K_WR, 4'h2, 8'h11, 4'h0, t + 1);
      idle(1);
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_cmp++; if (rf_addr !== 4'h0 || rf_wr_data !== 8'h0) begin
         n_bad++; $display("FAIL midrst_data: got addr=%h data=%h want 0/0", rf_addr, rf_wr_data);
      end
      n_cmp++; if (alu_fun !== 4'hF || clk_div_en !== 1'b0) begin
         n_bad++; $display("FAIL midrst_ctrl: got alu_fun=%h clk_div_en=%b want f/0", alu_fun, clk_div_en);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      idle(1);
      send_byte(8'hAA, t);
      send_byte(8'h03, t);
      send_byte(8'h77, t);
      expect_ev(K_WR, 4'h3, 8'h77, 4'h0, t + 1);
      idle(4);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL midrst_event: got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_write();
      test_alu_back_to_back();
      test_burst();
      test_errors();
      test_timeout();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL tb_time_limit: simulation still running, want finished");
      $fatal(1);
   end

endmodule
